// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the LEGv8-subset multi-cycle core.
// Opcode/state enums, control bundle and field encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_PC_INIT = 4'd0,
    OP_ADDI    = 4'd1,
    OP_ADDS    = 4'd2,
    OP_BLT     = 4'd3,
    OP_B       = 4'd4,
    OP_CBZ     = 4'd5,
    OP_LDUR    = 4'd6,
    OP_LSL     = 4'd7,
    OP_LSR     = 4'd8,
    OP_MUL     = 4'd9,
    OP_STUR    = 4'd10,
    OP_SUBS    = 4'd11
  } opcode_e;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MUL_WAIT,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_MUL = 2'd2;
  localparam logic [1:0] MTR_SHF = 2'd3;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_write;
  } ctl_t;

  function automatic logic is_illegal(
    input logic [3:0] op
  );
    return op > 4'd11;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory handshakes.
// master = sequencer, slave = memory side.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_control.sv
// control: combinational static-field decoder.
// Pure function of the opcode; callers gate by state.
module control
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output ctl_t       ctl
);

  opcode_e op_e;
  assign op_e = opcode_e'(op);

  // decode static datapath fields from the opcode
  always_comb begin
    ctl = '0;
    ctl.reg2loc = !(op_e == OP_STUR
                 || op_e == OP_CBZ);
    ctl.alu_src = {op_e == OP_ADDI,
                   op_e == OP_LDUR
                   || op_e == OP_STUR};
    ctl.alu_op  = ALU_ADD;
    ctl.mem_to_reg = MTR_ALU;
    unique case (op_e)
      OP_SUBS: ctl.alu_op = ALU_SUB;
      OP_CBZ:  ctl.alu_op = ALU_PASS;
      default: ctl.alu_op = ALU_ADD;
    endcase
    unique case (op_e)
      OP_LDUR:        ctl.mem_to_reg = MTR_MEM;
      OP_MUL:         ctl.mem_to_reg = MTR_MUL;
      OP_LSL, OP_LSR: ctl.mem_to_reg = MTR_SHF;
      default:        ctl.mem_to_reg = MTR_ALU;
    endcase
    unique case (op_e)
      OP_ADDI, OP_ADDS, OP_SUBS,
      OP_LSL, OP_LSR, OP_MUL,
      OP_LDUR: ctl.reg_write = 1'b1;
      default: ctl.reg_write = 1'b0;
    endcase
    ctl.mem_write = (op_e == OP_STUR);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/MUL_WAIT/WB sequencer.
// Owns memory handshakes, multiplier wait and datapath enables.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         opcode,
  input  logic               flag_z,
  input  logic               flag_lt,
  multicycle_ctrl_if.master  mem,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               reg2loc,
  output logic [1:0]         alu_src,
  output logic [2:0]         alu_op,
  output logic [1:0]         mem_to_reg,
  output logic               flag_write,
  output logic               mul_start,
  output logic               illegal
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LD =
    CW'(MUL_LAT - 1);

  state_e        state_q;
  state_e        state_d;
  logic [3:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          ill_q;
  opcode_e       op_e;
  ctl_t          ctl;
  logic          in_win;

  assign op_e    = opcode_e'(op_q);
  assign illegal = ill_q;
  assign in_win  = state_q inside {
    S_DECODE, S_EXEC, S_MEM,
    S_MUL_WAIT, S_WB};

  control u_control (
    .op  (op_q),
    .ctl (ctl)
  );

  // state, latched opcode, mul counter, sticky illegal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (is_illegal(opcode))
          ill_q <= 1'b1;
      end
      if (state_q == S_EXEC
          && op_e == OP_MUL)
        cnt_q <= CNT_LD;
      else if (state_q == S_MUL_WAIT
               && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH:
        if (mem.imem_ready)
          state_d = S_DECODE;
      S_DECODE:
        if (is_illegal(opcode))
          state_d = S_HALT;
        else if (opcode == OP_PC_INIT)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      S_EXEC:
        unique case (op_e)
          OP_ADDI, OP_ADDS, OP_SUBS,
          OP_LSL, OP_LSR:
            state_d = S_WB;
          OP_LDUR, OP_STUR:
            state_d = S_MEM;
          OP_MUL:
            state_d = S_MUL_WAIT;
          default:
            state_d = S_FETCH;
        endcase
      S_MEM:
        if (mem.dmem_ready)
          state_d = (op_e == OP_LDUR)
                    ? S_WB : S_FETCH;
      S_MUL_WAIT:
        if (cnt_q == '0)
          state_d = S_WB;
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // per-state enables and static fields
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    flag_write   = 1'b0;
    mul_start    = 1'b0;
    reg2loc      = 1'b0;
    alu_src      = '0;
    alu_op       = '0;
    mem_to_reg   = '0;
    if (in_win) begin
      reg2loc    = ctl.reg2loc;
      alu_src    = ctl.alu_src;
      alu_op     = ctl.alu_op;
      mem_to_reg = ctl.mem_to_reg;
    end
    unique case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_load      = mem.imem_ready;
        pc_write     = mem.imem_ready;
      end
      S_EXEC:
        unique case (op_e)
          OP_ADDS, OP_SUBS:
            flag_write = 1'b1;
          OP_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          OP_BLT: begin
            pc_write = flag_lt;
            pc_src   = 1'b1;
          end
          OP_CBZ: begin
            pc_write = flag_z;
            pc_src   = 1'b1;
          end
          OP_MUL:
            mul_start = 1'b1;
          default: ;
        endcase
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = ctl.mem_write;
      end
      S_WB:
        reg_write = ctl.reg_write;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the sequencer.
// Per-cycle expected vectors queued with stimulus, compared at negedge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_write;
    logic       pc_src;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       reg2loc;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       flag_write;
    logic       mul_start;
    logic       illegal;
  } vec_t;

  typedef struct packed {
    logic [3:0] op;
    logic       ir;
    logic       dr;
    logic       fz;
    logic       flt;
    logic       rst;
  } stim_t;

  typedef struct {
    vec_t  v;
    string name;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] opcode;
  logic       flag_z;
  logic       flag_lt;

  multicycle_ctrl_if bus0 ();
  multicycle_ctrl_if bus1 ();

  logic       ir_load0, pc_write0, pc_src0;
  logic       reg_write0, reg2loc0;
  logic [1:0] alu_src0, mem_to_reg0;
  logic [2:0] alu_op0;
  logic       flag_write0, mul_start0, illegal0;
  logic       ir_load1, pc_write1, pc_src1;
  logic       reg_write1, reg2loc1;
  logic [1:0] alu_src1, mem_to_reg1;
  logic [2:0] alu_op1;
  logic       flag_write1, mul_start1, illegal1;

  multicycle_ctrl #(.MUL_LAT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_lt    (flag_lt),
    .mem        (bus0),
    .ir_load    (ir_load0),
    .pc_write   (pc_write0),
    .pc_src     (pc_src0),
    .reg_write  (reg_write0),
    .reg2loc    (reg2loc0),
    .alu_src    (alu_src0),
    .alu_op     (alu_op0),
    .mem_to_reg (mem_to_reg0),
    .flag_write (flag_write0),
    .mul_start  (mul_start0),
    .illegal    (illegal0)
  );

  multicycle_ctrl #(.MUL_LAT(1)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_lt    (flag_lt),
    .mem        (bus1),
    .ir_load    (ir_load1),
    .pc_write   (pc_write1),
    .pc_src     (pc_src1),
    .reg_write  (reg_write1),
    .reg2loc    (reg2loc1),
    .alu_src    (alu_src1),
    .alu_op     (alu_op1),
    .mem_to_reg (mem_to_reg1),
    .flag_write (flag_write1),
    .mul_start  (mul_start1),
    .illegal    (illegal1)
  );

  vec_t o0, o1;
  assign o0 = {bus0.imem_req, ir_load0,
    pc_write0, pc_src0, bus0.dmem_req,
    bus0.dmem_we, reg_write0, reg2loc0,
    alu_src0, alu_op0, mem_to_reg0,
    flag_write0, mul_start0, illegal0};
  assign o1 = {bus1.imem_req, ir_load1,
    pc_write1, pc_src1, bus1.dmem_req,
    bus1.dmem_we, reg_write1, reg2loc1,
    alu_src1, alu_op1, mem_to_reg1,
    flag_write1, mul_start1, illegal1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  stim_t sq[$];
  exp_t  eq[$];
  logic [3:0] last_op;

  function automatic vec_t sf(
    input logic [3:0] op
  );
    vec_t v;
    v = '0;
    v.reg2loc = !(op == 4'd5 || op == 4'd10);
    v.alu_src = {op == 4'd1,
                 op == 4'd6 || op == 4'd10};
    if (op == 4'd11)     v.alu_op = 3'd3;
    else if (op == 4'd5) v.alu_op = 3'd0;
    else                 v.alu_op = 3'd2;
    if (op == 4'd6)      v.mem_to_reg = 2'd1;
    else if (op == 4'd9) v.mem_to_reg = 2'd2;
    else if (op == 4'd7 || op == 4'd8)
      v.mem_to_reg = 2'd3;
    else                 v.mem_to_reg = 2'd0;
    return v;
  endfunction

  task automatic ps(
    input logic [3:0] op,
    input logic ir, dr, fz, flt, rst,
    input vec_t v,
    input string name
  );
    exp_t e;
    sq.push_back({op, ir, dr, fz, flt, rst});
    e.v = v;
    e.name = name;
    eq.push_back(e);
  endtask

  task automatic push_reset();
    ps(4'd0, 0, 0, 0, 0, 0, '0, "rst_hold");
    ps(4'd0, 0, 0, 0, 0, 0, '0, "rst_hold2");
    ps(4'd0, 0, 0, 0, 0, 1, '0, "rst_state");
    last_op = 4'd0;
  endtask

  task automatic push_instr(
    input logic [3:0] op,
    input int iw, dw,
    input logic fz, flt,
    input int lat,
    input logic nz
  );
    vec_t v;
    for (int i = 0; i < iw; i++) begin
      v = '0;
      v.imem_req = 1'b1;
      ps(op, 0, nz, fz, flt, 1, v, "fetch_wait");
    end
    v = '0;
    v.imem_req = 1'b1;
    v.ir_load  = 1'b1;
    v.pc_write = 1'b1;
    ps(op, 1, nz, fz, flt, 1, v, "fetch");
    v = sf(last_op);
    ps(op, nz, nz, fz, flt, 1, v, "decode");
    last_op = op;
    if (op == 4'd0) return;
    v = sf(op);
    case (op)
      4'd2, 4'd11: v.flag_write = 1'b1;
      4'd3: begin
        v.pc_write = flt;
        v.pc_src   = 1'b1;
      end
      4'd4: begin
        v.pc_write = 1'b1;
        v.pc_src   = 1'b1;
      end
      4'd5: begin
        v.pc_write = fz;
        v.pc_src   = 1'b1;
      end
      4'd9: v.mul_start = 1'b1;
      default: ;
    endcase
    ps(op, nz, nz, fz, flt, 1, v, "exec");
    if (op == 4'd3 || op == 4'd4
        || op == 4'd5) return;
    if (op == 4'd6 || op == 4'd10) begin
      v = sf(op);
      v.dmem_req = 1'b1;
      v.dmem_we  = (op == 4'd10);
      for (int i = 0; i < dw; i++)
        ps(op, nz, 0, fz, flt, 1, v, "mem_wait");
      ps(op, nz, 1, fz, flt, 1, v, "mem_done");
      if (op == 4'd10) return;
    end
    if (op == 4'd9)
      for (int i = 0; i < lat; i++)
        ps(op, nz, nz, fz, flt, 1, sf(op),
           "mul_wait");
    v = sf(op);
    v.reg_write = 1'b1;
    ps(op, nz, nz, fz, flt, 1, v, "wb");
  endtask

  task automatic run(input bit sel);
    stim_t s;
    exp_t  e;
    vec_t  got;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      opcode  = s.op;
      bus0.imem_ready = s.ir;
      bus1.imem_ready = s.ir;
      bus0.dmem_ready = s.dr;
      bus1.dmem_ready = s.dr;
      flag_z  = s.fz;
      flag_lt = s.flt;
      reset_n = s.rst;
      @(negedge clk);
      got = sel ? o1 : o0;
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h",
                 e.name, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    vec_t v;
    push_reset();
    v = '0;
    v.imem_req = 1'b1;
    v.ir_load  = 1'b1;
    v.pc_write = 1'b1;
    ps(4'd10, 1, 0, 0, 0, 1, v, "stur_fetch");
    ps(4'd10, 0, 0, 0, 0, 1, sf(4'd0),
       "stur_decode");
    ps(4'd10, 0, 0, 0, 0, 1, sf(4'd10),
       "stur_exec");
    v = sf(4'd10);
    v.dmem_req = 1'b1;
    v.dmem_we  = 1'b1;
    ps(4'd10, 0, 0, 0, 0, 1, v, "stur_mem0");
    ps(4'd10, 0, 0, 0, 0, 1, v, "stur_mem1");
    push_reset();
    v = '0;
    v.imem_req = 1'b1;
    ps(4'd0, 0, 0, 0, 0, 1, v, "post_rst_fetch");
    run(0);
  endtask

  task automatic test_adds();
    push_instr(4'd2, 0, 0, 0, 0, 0, 0);
    run(0);
  endtask

  task automatic test_cbz();
    push_instr(4'd5, 0, 0, 1, 0, 0, 0);
    push_instr(4'd5, 0, 0, 0, 0, 0, 0);
    run(0);
  endtask

  task automatic test_ldur();
    push_instr(4'd6, 0, 3, 0, 0, 0, 0);
    run(0);
  endtask

  task automatic test_mul();
    push_instr(4'd9, 0, 0, 0, 0, 4, 0);
    run(0);
  endtask

  task automatic test_back_to_back();
    push_instr(4'd4,  0, 0, 0, 0, 0, 0);
    push_instr(4'd3,  0, 0, 0, 1, 0, 0);
    push_instr(4'd3,  1, 0, 1, 0, 0, 0);
    push_instr(4'd1,  2, 0, 0, 0, 0, 1);
    push_instr(4'd0,  0, 0, 0, 0, 0, 0);
    push_instr(4'd11, 0, 0, 0, 0, 0, 1);
    push_instr(4'd10, 0, 1, 0, 0, 0, 1);
    push_instr(4'd7,  0, 0, 0, 0, 0, 0);
    push_instr(4'd8,  1, 0, 0, 0, 0, 1);
    push_instr(4'd6,  0, 0, 0, 0, 0, 1);
    run(0);
  endtask

  task automatic test_mul_lat1();
    push_reset();
    push_instr(4'd9, 0, 0, 0, 0, 1, 0);
    push_instr(4'd2, 0, 0, 0, 0, 0, 0);
    run(1);
  endtask

  task automatic test_illegal();
    vec_t v;
    push_reset();
    v = '0;
    v.imem_req = 1'b1;
    v.ir_load  = 1'b1;
    v.pc_write = 1'b1;
    ps(4'd13, 1, 0, 0, 0, 1, v, "ill_fetch");
    ps(4'd13, 0, 0, 0, 0, 1, sf(4'd0),
       "ill_decode");
    v = '0;
    v.illegal = 1'b1;
    for (int i = 0; i < 20; i++)
      ps(4'd13, 1, 1, 1, 1, 1, v, "halt");
    push_reset();
    v = '0;
    v.imem_req = 1'b1;
    ps(4'd0, 0, 0, 0, 0, 1, v, "ill_cleared");
    run(0);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = '0;
    flag_z  = 1'b0;
    flag_lt = 1'b0;
    bus0.imem_ready = 1'b0;
    bus1.imem_ready = 1'b0;
    bus0.dmem_ready = 1'b0;
    bus1.dmem_ready = 1'b0;
    last_op = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_adds();
    test_cbz();
    test_ldur();
    test_mul();
    test_back_to_back();
    test_mul_lat1();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
